// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: address map constants, region-select enum and address decoder shared by mem_responder.
package mem_resp_pkg;
  localparam logic [31:0] RAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] LED_ADDR   = 32'h0000_1000;
  localparam logic [31:0] SW_ADDR    = 32'h0000_1001;
  localparam logic [31:0] TIMER_ADDR = 32'h0000_1002;
  localparam logic [31:0] TSTAT_ADDR = 32'h0000_1003;
  typedef enum logic [2:0] {
    REG_NONE,
    REG_RAM,
    REG_LED,
    REG_SW,
    REG_TIMER,
    REG_TSTAT
  } region_e;
  function automatic region_e decode(input logic [31:0] a, input int depth, input logic timer_en);
    return (a - RAM_BASE < 32'(depth)) ? REG_RAM :
           (a == LED_ADDR)             ? REG_LED :
           (a == SW_ADDR)              ? REG_SW  :
           (timer_en && a == TIMER_ADDR) ? REG_TIMER :
           (timer_en && a == TSTAT_ADDR) ? REG_TSTAT : REG_NONE;
  endfunction
endpackage

// File: rtl/mem_resp_sync.sv
// mem_resp_sync: two-flop synchronizer; ports clk, reset (sync active-high), d_i (async in), q_o (synchronized out).
module mem_resp_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] s1_q, s2_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end
  assign q_o = s2_q;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: processor-side RAM + LED/SW/TIMER/TSTAT responder; ports clk, reset, addr, wdata, we, rdata, sw, leds; timer block enabled by MEM_RESP_TIMER_EN.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int PRESCALE    = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  input  logic [9:0]  sw,
  output logic [9:0]  leds
);
  localparam int AW = $clog2(DEPTH_WORDS);
`ifdef MEM_RESP_TIMER_EN
  localparam logic TIMER_EN = 1'b1;
`else
  localparam logic TIMER_EN = 1'b0;
`endif
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q, rdata_d, tmr_rd;
  logic [9:0]  led_q, led_d, sw_s;
  logic        wr;
  region_e     sel;
  mem_resp_sync #(.W(10)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (sw),
    .q_o   (sw_s)
  );
  always_comb begin
    sel = decode(addr, DEPTH_WORDS, TIMER_EN);
    wr = we && !reset;
    led_d = (wr && sel == REG_LED) ? wdata[9:0] : led_q;
    rdata_d = sel == REG_RAM ? (we ? wdata : mem[addr[AW-1:0]]) :
              sel == REG_LED ? {22'b0, led_d} :
              sel == REG_SW  ? {22'b0, sw_s} :
              (sel == REG_TIMER || sel == REG_TSTAT) ? tmr_rd : '0;
  end
  always_ff @(posedge clk) begin
    if (wr && sel == REG_RAM) mem[addr[AW-1:0]] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      led_q <= '0;
    end else begin
      rdata_q <= rdata_d;
      led_q <= led_d;
    end
  end
`ifdef MEM_RESP_TIMER_EN
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   timer_q, timer_d;
  logic          tstat_q, tstat_d, tick, wr_timer;
  always_comb begin
    tick = presc_q == PW'(PRESCALE - 1);
    wr_timer = wr && sel == REG_TIMER;
    presc_d = (tick || wr_timer) ? '0 : presc_q + 1'b1;
    timer_d = wr_timer ? wdata : tick ? timer_q + 32'd1 : timer_q;
    // overflow set beats a same-cycle clear; a TIMER load suppresses the tick entirely
    tstat_d = (tick && &timer_q && !wr_timer) ? 1'b1 : (wr && sel == REG_TSTAT) ? 1'b0 : tstat_q;
    tmr_rd = sel == REG_TIMER ? timer_d : {31'b0, tstat_d};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      timer_q <= '0;
      tstat_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      timer_q <= timer_d;
      tstat_q <= tstat_d;
    end
  end
`else
  logic unused_prescale;
  assign unused_prescale = ^PRESCALE;
  assign tmr_rd = '0;
`endif
  assign rdata = rdata_q;
  assign leds = led_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata;
  logic        we;
  logic [9:0]  sw, leds;
  int checks = 0;
  int errors = 0;
  mem_responder #(.DEPTH_WORDS(256), .PRESCALE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .rdata (rdata),
    .sw    (sw),
    .leds  (leds)
  );
  always #5 clk = ~clk;
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b1; we = 1'b0; addr = '0; wdata = '0; sw = '0;
    step(2);
    check("reset_rdata", rdata, 32'h0);
    check("reset_leds", {22'b0, leds}, 32'h0);
    reset = 1'b0;
    we = 1'b1; addr = 32'h10; wdata = 32'hDEAD_BEEF;
    step();
    check("ram_write_first", rdata, 32'hDEAD_BEEF);
    we = 1'b0; addr = 32'h10;
    step();
    check("ram_read", rdata, 32'hDEAD_BEEF);
    we = 1'b1; addr = 32'h0; wdata = 32'h1111_1111;
    step();
    addr = 32'h100; wdata = 32'h0000_0055;
    step();
    check("unmapped_0x100_write", rdata, 32'h0);
    we = 1'b0; addr = 32'h0;
    step();
    check("ram_no_alias", rdata, 32'h1111_1111);
    addr = 32'h2000;
    step();
    check("unmapped_read", rdata, 32'h0);
    we = 1'b1; wdata = 32'h1234;
    step();
    check("unmapped_write", rdata, 32'h0);
    check("unmapped_write_leds", {22'b0, leds}, 32'h0);
    we = 1'b0; addr = 32'h10;
    step();
    check("ram_after_unmapped", rdata, 32'hDEAD_BEEF);
    we = 1'b1; addr = 32'h1000; wdata = 32'hFFFF_F3A5;
    step();
    check("led_write_first", rdata, 32'h0000_03A5);
    check("led_pins", {22'b0, leds}, 32'h0000_03A5);
    we = 1'b0;
    step();
    check("led_read", rdata, 32'h0000_03A5);
    reset = 1'b1;
    step();
    check("reset2_leds", {22'b0, leds}, 32'h0);
    check("reset2_rdata", rdata, 32'h0);
    reset = 1'b0; addr = 32'h10;
    step();
    check("ram_persists_reset", rdata, 32'hDEAD_BEEF);
    addr = 32'h1000;
    step();
    check("led_read_after_reset", rdata, 32'h0);
    addr = 32'h1001; sw = 10'h155;
    step();
    check("sw_edge1", rdata, 32'h0);
    step();
    check("sw_edge2", rdata, 32'h0);
    step();
    check("sw_edge3", rdata, 32'h155);
    we = 1'b1; wdata = 32'h0;
    step();
    check("sw_write_ignored", rdata, 32'h155);
    we = 1'b0;
`ifdef MEM_RESP_TIMER_EN
    we = 1'b1; addr = 32'h1002; wdata = 32'hFFFF_FFFE;
    step();
    check("timer_load", rdata, 32'hFFFF_FFFE);
    we = 1'b0;
    step(3);
    check("timer_no_tick_yet", rdata, 32'hFFFF_FFFE);
    step();
    check("timer_tick1", rdata, 32'hFFFF_FFFF);
    addr = 32'h1003;
    step();
    check("tstat_before_wrap", rdata, 32'h0);
    addr = 32'h1002;
    step(3);
    check("timer_wrap", rdata, 32'h0);
    addr = 32'h1003;
    step();
    check("tstat_sticky", rdata, 32'h1);
    we = 1'b1;
    step();
    check("tstat_clear", rdata, 32'h0);
    we = 1'b0;
    step();
    check("tstat_stays_clear", rdata, 32'h0);
`else
    addr = 32'h1002;
    step();
    check("timer_unmapped", rdata, 32'h0);
    step(20);
    check("timer_unmapped_later", rdata, 32'h0);
    we = 1'b1; wdata = 32'h5;
    step();
    check("timer_write_unmapped", rdata, 32'h0);
    we = 1'b0; addr = 32'h1003;
    step();
    check("tstat_unmapped", rdata, 32'h0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
